// File: rtl/ex_mem_pipe_stage_pkg.sv
// Shared EX/MEM pipeline types.
// Access-size codes, control bundle and skid states.
package ex_mem_pipe_stage_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       reg_write;
    logic       mem_to_reg;
  } ex_mem_ctrl_t;

  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ex_mem_pipe_stage_skid_buf.sv
// Generic 2-entry skid buffer (or single register).
// Head entry drives the output; skid entry absorbs a stall.
module pipe_skid_buf
  import ex_mem_pipe_stage_pkg::*;
#(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_e  state_q;
  logic         ready_q;
  logic [W-1:0] head_q;
  logic [W-1:0] skid_q;
  logic         in_fire;
  logic         out_fire;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = head_q;
  assign in_ready_o  = SKID_EN ? ready_q
                     : (!out_valid_o || out_ready_i);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  // Occupancy FSM; flush beats any handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            head_q  <= in_data_i;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            head_q <= in_data_i;
          end else if (in_fire && SKID_EN) begin
            skid_q  <= in_data_i;
            state_q <= ST_FULL;
            ready_q <= 1'b0;
          end else if (out_fire) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            head_q  <= skid_q;
            state_q <= ST_ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage with handshake and flush.
// Side-effect controls are gated by out_valid.
module ex_mem_pipe_stage
  import ex_mem_pipe_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit SKID_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [1:0]            mem_size_in,
  input  logic                  mem_unsigned_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     write_data_in,
  input  logic [REG_ADDR_W-1:0] write_reg_addr_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            mem_size,
  output logic                  mem_unsigned,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic [DATA_W-1:0]     alu_result,
  output logic [DATA_W-1:0]     write_data,
  output logic [REG_ADDR_W-1:0] write_reg_addr
);

  localparam int PL_W = EX_MEM_CTRL_W + 2*DATA_W + REG_ADDR_W;

  ex_mem_ctrl_t    ctrl_in;
  ex_mem_ctrl_t    ctrl_out;
  logic [PL_W-1:0] pl_in;
  logic [PL_W-1:0] pl_out;

  assign ctrl_in.mem_read     = mem_read_in;
  assign ctrl_in.mem_write    = mem_write_in;
  assign ctrl_in.mem_size     = mem_size_in;
  assign ctrl_in.mem_unsigned = mem_unsigned_in;
  assign ctrl_in.reg_write    = reg_write_in;
  assign ctrl_in.mem_to_reg   = mem_to_reg_in;

  assign pl_in = {ctrl_in, alu_result_in,
                  write_data_in, write_reg_addr_in};

  pipe_skid_buf #(
    .W       (PL_W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk_i       (clk),
    .rst_i       (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (pl_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (pl_out)
  );

  assign {ctrl_out, alu_result,
          write_data, write_reg_addr} = pl_out;

  assign mem_read     = ctrl_out.mem_read  & out_valid;
  assign mem_write    = ctrl_out.mem_write & out_valid;
  assign reg_write    = ctrl_out.reg_write & out_valid;
  assign mem_size     = ctrl_out.mem_size;
  assign mem_unsigned = ctrl_out.mem_unsigned;
  assign mem_to_reg   = ctrl_out.mem_to_reg;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage, skid and no-skid builds.
// Vector table, corner sequences and random scoreboard.
module tb_ex_mem_pipe_stage;

  typedef struct packed {
    logic        mr;
    logic        mw;
    logic [1:0]  sz;
    logic        un;
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
  } pl_t;

  typedef struct {
    logic        iv, ordy, fl, mr, mw, rw;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        e_ov, e_ird, cd;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
    logic        e_rw, e_mw, e_mr;
  } vec_t;

  logic clk, reset, flush, in_valid, out_ready;
  pl_t  in_pl;

  logic mr_in, mw_in, un_in, rw_in, m2r_in;
  logic [1:0] sz_in;
  logic [31:0] alu_in, wd_in;
  logic [4:0] rd_in;
  assign {mr_in, mw_in, sz_in, un_in, rw_in,
          m2r_in, alu_in, wd_in, rd_in} = in_pl;

  logic ird [2];
  logic ov [2];
  logic mr [2], mw [2], un [2], rw [2], m2r [2];
  logic [1:0] sz [2];
  logic [31:0] alu [2], wd [2];
  logic [4:0] rd [2];
  pl_t obs [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ex_mem_pipe_stage #(
      .DATA_W(32), .REG_ADDR_W(5), .SKID_EN(g == 1)
    ) u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ird[g]),
      .mem_read_in(mr_in), .mem_write_in(mw_in),
      .mem_size_in(sz_in), .mem_unsigned_in(un_in),
      .reg_write_in(rw_in), .mem_to_reg_in(m2r_in),
      .alu_result_in(alu_in), .write_data_in(wd_in),
      .write_reg_addr_in(rd_in),
      .out_valid(ov[g]), .out_ready(out_ready),
      .mem_read(mr[g]), .mem_write(mw[g]),
      .mem_size(sz[g]), .mem_unsigned(un[g]),
      .reg_write(rw[g]), .mem_to_reg(m2r[g]),
      .alu_result(alu[g]), .write_data(wd[g]),
      .write_reg_addr(rd[g])
    );
    assign obs[g] = {mr[g], mw[g], sz[g], un[g], rw[g],
                     m2r[g], alu[g], wd[g], rd[g]};
  end

  int total = 0;
  int bad = 0;
  pl_t q [2][$];
  vec_t tv [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic vec_t v(
      logic iv, logic ordy, logic fl, logic vmr,
      logic vmw, logic vrw, logic [31:0] a,
      logic [4:0] r, logic eov, logic eird, logic cd,
      logic [31:0] ea, logic [4:0] er, logic erw,
      logic emw, logic emr);
    vec_t t;
    t.iv = iv; t.ordy = ordy; t.fl = fl;
    t.mr = vmr; t.mw = vmw; t.rw = vrw;
    t.alu = a; t.rd = r;
    t.e_ov = eov; t.e_ird = eird; t.cd = cd;
    t.e_alu = ea; t.e_rd = er;
    t.e_rw = erw; t.e_mw = emw; t.e_mr = emr;
    return t;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_pl = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q[0].delete();
    q[1].delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input int k);
    logic er;
    bit   o, i;
    er = (k == 1) ? (q[k].size() < 2)
                  : (q[k].size() == 0 || out_ready);
    chk($sformatf("rnd_ready%0d", k), ird[k], er);
    chk($sformatf("rnd_valid%0d", k), ov[k],
        q[k].size() != 0);
    if (q[k].size() != 0)
      chk($sformatf("rnd_head%0d", k), obs[k], q[k][0]);
    else
      chk($sformatf("rnd_gate%0d", k),
          {mr[k], mw[k], rw[k]}, 3'b000);
    if (flush) begin
      q[k].delete();
    end else begin
      o = (q[k].size() != 0) && out_ready;
      i = in_valid && er;
      if (o) void'(q[k].pop_front());
      if (i) q[k].push_back(in_pl);
    end
  endtask

  initial begin
    tv[0]  = v(1,1,0, 0,0,1, 32'h1004, 5'd9,
               1,1,1, 32'h1004, 5'd9, 1,0,0);
    tv[1]  = v(0,1,0, 0,0,0, 32'h0, 5'd0,
               0,1,0, 32'h0, 5'd0, 0,0,0);
    tv[2]  = v(1,0,0, 0,0,0, 32'h1, 5'd0,
               1,1,1, 32'h1, 5'd0, 0,0,0);
    tv[3]  = v(1,0,0, 0,0,0, 32'h2, 5'd0,
               1,0,1, 32'h1, 5'd0, 0,0,0);
    tv[4]  = v(1,0,0, 0,0,0, 32'h3, 5'd0,
               1,0,1, 32'h1, 5'd0, 0,0,0);
    tv[5]  = v(1,1,0, 0,0,0, 32'h3, 5'd0,
               1,1,1, 32'h2, 5'd0, 0,0,0);
    tv[6]  = v(1,1,0, 0,0,0, 32'h3, 5'd0,
               1,1,1, 32'h3, 5'd0, 0,0,0);
    tv[7]  = v(0,1,0, 0,0,0, 32'h0, 5'd0,
               0,1,0, 32'h0, 5'd0, 0,0,0);
    tv[8]  = v(1,0,0, 0,0,0, 32'h10, 5'd0,
               1,1,1, 32'h10, 5'd0, 0,0,0);
    tv[9]  = v(1,0,0, 0,0,0, 32'h11, 5'd0,
               1,0,1, 32'h10, 5'd0, 0,0,0);
    tv[10] = v(1,0,1, 0,1,0, 32'h55, 5'd0,
               0,1,0, 32'h0, 5'd0, 0,0,0);
    tv[11] = v(0,1,0, 0,0,0, 32'h0, 5'd0,
               0,1,0, 32'h0, 5'd0, 0,0,0);
    tv[12] = v(0,1,0, 1,1,0, 32'h0, 5'd0,
               0,1,0, 32'h0, 5'd0, 0,0,0);
    tv[13] = v(1,1,0, 0,1,0, 32'h2000, 5'd0,
               1,1,1, 32'h2000, 5'd0, 0,1,0);
    tv[14] = v(1,1,0, 1,0,1, 32'h2004, 5'd3,
               1,1,1, 32'h2004, 5'd3, 1,0,1);
    tv[15] = v(0,1,0, 0,0,0, 32'h0, 5'd0,
               0,1,0, 32'h0, 5'd0, 0,0,0);

    do_reset();
    chk("rst_valid", ov[1], 1'b0);
    chk("rst_ready", ird[1], 1'b1);
    chk("rst_fields", obs[1], '0);
    chk("rst_valid0", ov[0], 1'b0);

    for (int n = 0; n < 16; n++) begin
      in_valid  = tv[n].iv;
      out_ready = tv[n].ordy;
      flush     = tv[n].fl;
      in_pl     = '0;
      in_pl.mr  = tv[n].mr;
      in_pl.mw  = tv[n].mw;
      in_pl.rw  = tv[n].rw;
      in_pl.alu = tv[n].alu;
      in_pl.rd  = tv[n].rd;
      step();
      chk($sformatf("v%0d_valid", n), ov[1], tv[n].e_ov);
      chk($sformatf("v%0d_ready", n), ird[1], tv[n].e_ird);
      chk($sformatf("v%0d_ctl", n), {mr[1], mw[1], rw[1]},
          {tv[n].e_mr, tv[n].e_mw, tv[n].e_rw});
      if (tv[n].cd) begin
        chk($sformatf("v%0d_alu", n), alu[1], tv[n].e_alu);
        chk($sformatf("v%0d_rd", n), rd[1], tv[n].e_rd);
      end
    end

    idle_inputs();
    in_valid = 1'b1;
    in_pl.rw = 1'b1;
    in_pl.rd = 5'd7;
    in_pl.alu = 32'hA;
    step();
    in_pl.alu = 32'hB;
    step();
    chk("ar_full_ready", ird[1], 1'b0);
    chk("ar_full_valid", ov[1], 1'b1);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", ov[1], 1'b0);
    chk("ar_fields", obs[1], '0);
    chk("ar_ready", ird[1], 1'b1);
    chk("ar_valid0", ov[0], 1'b0);
    do_reset();

    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      in_pl = '0;
      in_pl.alu = 32'h100 + n;
      in_pl.wd = 32'hF00 - n;
      step();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tp%0d_valid%0d", n, k), ov[k], 1'b1);
        chk($sformatf("tp%0d_alu%0d", n, k),
            alu[k], 32'h100 + n);
        chk($sformatf("tp%0d_wd%0d", n, k),
            wd[k], 32'hF00 - n);
        chk($sformatf("tp%0d_ready%0d", n, k), ird[k], 1'b1);
      end
    end
    in_valid = 1'b0;
    step();
    chk("tp_end0", ov[0], 1'b0);
    chk("tp_end1", ov[1], 1'b0);

    do_reset();
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_pl = {$urandom, $urandom, $urandom};
      #3;
      sb_check(0);
      sb_check(1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_stage.md
Name: ex_mem_pipe_stage

Overview:
- Parametrised EX->MEM pipeline stage, the successor to the plain EX/MEM latch.
- Adds valid/ready handshake on both sides, a 2-entry skid buffer that absorbs a MEM-side stall, and a flush that kills in-flight instructions.
- Generalised data and register-address widths.
- Sits between the ALU/forwarding logic (EX) and the data-memory interface (MEM); the hazard unit drives flush.

Parameters:
- DATA_W, 32, width of alu_result and write_data
- REG_ADDR_W, 5, width of the destination register address
- SKID_EN, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single register (in_ready = !out_valid || out_ready)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous kill of every held entry
- in_valid  input  1  EX presents an instruction
- in_ready  output  1  stage can accept this cycle
- mem_read_in  input  1  load control
- mem_write_in  input  1  store control
- mem_size_in  input  2  access size: 0 = byte, 1 = half, 2 = word
- mem_unsigned_in  input  1  zero-extend load
- reg_write_in  input  1  WB register write
- mem_to_reg_in  input  1  WB select memory data
- alu_result_in  input  DATA_W  address or result
- write_data_in  input  DATA_W  store data
- write_reg_addr_in  input  REG_ADDR_W  destination register
- out_valid  output  1  MEM-side entry valid
- out_ready  input  1  MEM accepts this cycle
- mem_read, mem_write, mem_size, mem_unsigned, reg_write, mem_to_reg, alu_result, write_data, write_reg_addr  outputs, same widths as inputs  head-entry fields

Behaviour:
- Reset (asynchronous):
  - out_valid = 0, skid entry invalid, all output fields 0.
  - in_ready = 1 on the first cycle after reset deasserts.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - Latency is 1 cycle: data accepted at edge N is visible on the outputs after edge N.
- Side-effect gating: mem_read, mem_write and reg_write are ANDed with out_valid, so a bubble never writes memory or registers. Data fields may hold stale values while out_valid = 0.
- SKID_EN = 1 state machine:
  - EMPTY: head invalid. Accept -> ONE.
  - ONE: head valid.
    - Accept and output transfer together -> ONE (head replaced).
    - Accept without output transfer -> FULL (new data goes to the skid entry).
    - Output transfer only -> EMPTY.
  - FULL: head and skid valid; in_ready = 0. Output transfer -> ONE, skid moves to head in the same edge.
  - in_ready is registered: in_ready = !(state == FULL). No combinational path from out_ready to in_ready.
- SKID_EN = 0:
  - States EMPTY/ONE only.
  - in_ready = !out_valid || out_ready (combinational).
- Ordering: strictly FIFO; the skid entry never bypasses the head.
- Flush:
  - Next state is EMPTY: out_valid = 0, skid invalid.
  - Any input offered in the same cycle is dropped.
  - Flush has priority over every handshake.
  - in_ready = 1 on the following cycle.
- No gaps: back-to-back transfers at 1 per cycle whenever out_ready stays 1.
- Reset mid-FULL: both entries are discarded immediately (asynchronous).
- Widths: pure transport; no arithmetic and no extension inside the stage.

Decomposition:
- Shared pipeline package holds:
  - mem_size encodings SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2
  - the ex_mem control bundle (packed fields and its total width constant), so ID/EX and MEM/WB stages reuse it
- One natural sub-module: pipe_skid_buf, a generic payload-width 2-entry skid buffer. This block packs the control and data fields into one vector, instantiates it, then unpacks and gates the outputs.

Test Plan:
- Reset then single op: in_valid = 1 with alu_result_in = 32'h0000_1004, write_reg_addr_in = 5'd9, reg_write_in = 1, out_ready = 1 -> next cycle out_valid = 1, alu_result = 32'h0000_1004, write_reg_addr = 9, reg_write = 1. The following cycle (no input) out_valid = 0 and reg_write = 0.
- Stall fill: stream A = 1, B = 2, C = 3 with out_ready = 0 from the cycle A appears -> A held at the head, B in the skid entry, in_ready = 0, C not accepted (in_valid held). Release out_ready -> outputs A, B, C on consecutive cycles, in order, none lost or duplicated.
- Flush while FULL, with a store (mem_write_in = 1) offered the same cycle -> next cycle out_valid = 0, mem_write = 0, in_ready = 1. The offered store never appears at the output.
- Bubble gating: in_valid = 0 with mem_write_in = 1 and mem_read_in = 1 -> mem_write = 0 and mem_read = 0 on the outputs.
- Asynchronous reset asserted between clock edges while FULL -> all outputs 0 immediately, without waiting for a clock edge.
- Throughput with SKID_EN = 0 and SKID_EN = 1: 16 back-to-back ops with out_ready = 1 -> 16 outputs in 16 consecutive cycles, data equal to the inputs. A randomized out_ready with a scoreboard shows no loss or reorder.
